// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: RV32I byte/half/word data memory with configurable latency and error reporting
module data_memory_ctrl #(
  parameter int          NUM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          LATENCY   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int          IW       = $clog2(NUM_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * NUM_WORDS);
  localparam bit          L0       = (LATENCY == 0);
  localparam logic [3:0]  CNT_INIT = 4'(L0 ? 0 : LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [NUM_WORDS];
  logic        l_we;
  logic [2:0]  l_f3;
  logic [31:0] l_addr, l_wdata;
  logic        accept, go, a_we, err, wr;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata, off, word, ld, st_data, mask, st_word;
  logic [15:0] lane;
  logic [IW-1:0] idx;
  logic [3:0]  be;
  assign req_ready = state == IDLE || state == RESP;
  assign accept    = req_valid && req_ready;
  assign busy      = state == WAIT || (state == RESP && !accept);
  // With zero latency the access completes on the accepting edge, so it works from the live request
  assign go      = (accept && L0) || (state == WAIT && cnt == 4'd0);
  assign a_we    = L0 ? req_we     : l_we;
  assign a_f3    = L0 ? req_funct3 : l_f3;
  assign a_addr  = L0 ? req_addr   : l_addr;
  assign a_wdata = L0 ? req_wdata  : l_wdata;
  assign off  = a_addr - BASE_ADDR;
  assign idx  = off[2+IW-1:2];
  assign word = mem[idx];
  assign lane = 16'(word >> {off[1:0], 3'b000});
  assign err  = off >= SPAN
             || (a_we ? a_f3 > 3'd2 : (a_f3 == 3'd3 || a_f3 > 3'd5))
             || (a_f3[1:0] == 2'd1 && off[0])
             || (a_f3[1:0] == 2'd2 && off[1:0] != 2'd0);
  assign ld = a_f3 == 3'd0 ? {{24{lane[7]}}, lane[7:0]}
            : a_f3 == 3'd1 ? {{16{lane[15]}}, lane}
            : a_f3 == 3'd4 ? {24'h0, lane[7:0]}
            : a_f3 == 3'd5 ? {16'h0, lane}
            : word;
  assign be = a_f3[1:0] == 2'd0 ? 4'b0001 << off[1:0]
            : a_f3[1:0] == 2'd1 ? 4'b0011 << {off[1], 1'b0}
            : 4'b1111;
  assign st_data = a_f3[1:0] == 2'd0 ? {4{a_wdata[7:0]}}
                 : a_f3[1:0] == 2'd1 ? {2{a_wdata[15:0]}}
                 : a_wdata;
  assign mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign st_word = (word & ~mask) | (st_data & mask);
  assign wr      = go && a_we && !err && !rst;
  // Array write on the edge entering RESP; left unreset so it can map onto RAM
  always_ff @(posedge clk)
    if (wr) mem[idx] <= st_word;
  // Handshake FSM, latency counter, request latch and registered response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_f3      <= 3'd0;
      l_addr    <= 32'h0;
      l_wdata   <= 32'h0;
    end else begin
      rsp_valid <= go;
      rsp_err   <= go && err;
      rsp_rdata <= (go && !err && !a_we) ? ld : 32'h0;
      if (accept) begin
        l_we    <= req_we;
        l_f3    <= req_funct3;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        state   <= L0 ? RESP : WAIT;
        cnt     <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) state <= RESP;
      end else if (state == RESP) state <= IDLE;
    end
endmodule
